// File: rtl/pdu_input_cond_if.sv
// pdu_input_cond_if: raw board pins in, conditioned button/switch signals out
interface pdu_input_cond_if;
  logic butc, butu, butd, butl, butr;
  logic [15:0] sw;
  logic [4:0] btn_level, btn_pulse, btn_rep;
  logic [15:0] sw_stable;
  logic sw_chg;
  modport master(output butc, butu, butd, butl, butr, sw, input btn_level, btn_pulse, btn_rep, sw_stable, sw_chg);
  modport slave(input butc, butu, butd, butl, butr, sw, output btn_level, btn_pulse, btn_rep, sw_stable, sw_chg);
endinterface

// File: rtl/pdu_input_cond.sv
// pdu_input_cond: sync, debounce and auto-repeat for PDU buttons and switches
module pdu_input_cond #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int REP_DELAY  = 50_000_000,
  parameter int REP_PERIOD = 10_000_000,
  parameter int CNT_W      = 26
) (
  input logic clk,
  input logic rstn,
  pdu_input_cond_if.slave io
);
  localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(REP_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [4:0] b_raw, b_s1_q, b_s2_q, lvl, pls, rep;
  logic [15:0] s_s1_q, s_s2_q, s_prev_q, s_stb_q;
  logic [CNT_W-1:0] s_cnt_q, s_cnt_d;
  logic s_chg_q, s_com;
  assign b_raw = {io.butr, io.butl, io.butd, io.butu, io.butc};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      b_s1_q <= '0;
      b_s2_q <= '0;
      s_s1_q <= '0;
      s_s2_q <= '0;
      s_prev_q <= '0;
    end else begin
      b_s1_q <= b_raw;
      b_s2_q <= b_s1_q;
      s_s1_q <= io.sw;
      s_s2_q <= s_s1_q;
      s_prev_q <= s_s2_q;
    end
  for (genvar i = 0; i < 5; i++) begin : g_btn
    state_t st_q, st_d;
    logic [CNT_W-1:0] dc_q, dc_d, rc_q, rc_d;
    logic lvl_q, pls_q, flip, rep_d;
    always_comb begin
      flip = (b_s2_q[i] != lvl_q) && (dc_q == DEB_M1);
      dc_d = (b_s2_q[i] == lvl_q || flip) ? '0 : dc_q + 1'b1;
    end
    // Release is checked before expiry so a let-go never emits a stray repeat
    always_comb begin
      st_d = st_q;
      rc_d = rc_q + 1'b1;
      rep_d = 1'b0;
      if (st_q == IDLE) begin
        rc_d = '0;
        st_d = pls_q ? DELAY : IDLE;
        rep_d = pls_q;
      end else if (!lvl_q) begin
        st_d = IDLE;
        rc_d = '0;
      end else if (rc_q == ((st_q == DELAY) ? DLY_M1 : PER_M1)) begin
        st_d = REPEAT;
        rc_d = '0;
        rep_d = 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        lvl_q <= 1'b0;
        pls_q <= 1'b0;
        dc_q <= '0;
        rc_q <= '0;
        st_q <= IDLE;
      end else begin
        lvl_q <= flip ? b_s2_q[i] : lvl_q;
        pls_q <= flip & b_s2_q[i];
        dc_q <= dc_d;
        rc_q <= rc_d;
        st_q <= st_d;
      end
    assign lvl[i] = lvl_q;
    assign pls[i] = pls_q;
    assign rep[i] = rep_d;
  end
  // A fresh vector counts as the first stable cycle, matching the button latency
  always_comb begin
    s_com = (s_s2_q != s_stb_q) && (s_s2_q == s_prev_q) && (s_cnt_q == DEB_M1);
    s_cnt_d = (s_s2_q == s_stb_q || s_com) ? '0 : (s_s2_q != s_prev_q) ? CNT_W'(1) : s_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s_stb_q <= '0;
      s_chg_q <= 1'b0;
      s_cnt_q <= '0;
    end else begin
      s_stb_q <= s_com ? s_s2_q : s_stb_q;
      s_chg_q <= s_com;
      s_cnt_q <= s_cnt_d;
    end
  assign io.btn_level = lvl;
  assign io.btn_pulse = pls;
  assign io.btn_rep = rep;
  assign io.sw_stable = s_stb_q;
  assign io.sw_chg = s_chg_q;
endmodule

// File: tb/tb_pdu_input_cond.sv
// tb_pdu_input_cond: directed stimulus with an event scoreboard for pulse outputs
module tb_pdu_input_cond;
  typedef struct {
    int cyc;
    logic [4:0] pls;
    logic [4:0] rep;
    logic chg;
    logic [15:0] stb;
  } ev_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t q[$];
  pdu_input_cond_if bus();
  pdu_input_cond #(.DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(8), .CNT_W(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .io(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rstn) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: expected at cycle %0d, still absent at cycle %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (|bus.btn_pulse || |bus.btn_rep || bus.sw_chg) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cycle %0d pulse=%h rep=%h chg=%b stable=%h, required no event", cyc, bus.btn_pulse, bus.btn_rep, bus.sw_chg, bus.sw_stable);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.cyc != cyc || e.pls !== bus.btn_pulse || e.rep !== bus.btn_rep || e.chg !== bus.sw_chg || e.stb !== bus.sw_stable) begin
            errors++;
            $display("FAIL event: got cycle %0d pulse=%h rep=%h chg=%b stable=%h, required cycle %0d pulse=%h rep=%h chg=%b stable=%h", cyc, bus.btn_pulse, bus.btn_rep, bus.sw_chg, bus.sw_stable, e.cyc, e.pls, e.rep, e.chg, e.stb);
          end
        end
      end
    end
  task automatic expect_ev(input int c, input logic [4:0] p, input logic [4:0] r, input logic ch, input logic [15:0] s);
    ev_t e;
    e.cyc = c;
    e.pls = p;
    e.rep = r;
    e.chg = ch;
    e.stb = s;
    q.push_back(e);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 32'(bus.btn_level), 32'h0);
    chk({tag, "_pulse"}, 32'(bus.btn_pulse), 32'h0);
    chk({tag, "_rep"}, 32'(bus.btn_rep), 32'h0);
    chk({tag, "_stable"}, 32'(bus.sw_stable), 32'h0);
    chk({tag, "_chg"}, 32'(bus.sw_chg), 32'h0);
  endtask
  initial begin
    int c0;
    {bus.butc, bus.butu, bus.butd, bus.butl, bus.butr} = '0;
    bus.sw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;
    go(cyc + 4);
    // clean press on butc with auto-repeat
    c0 = cyc;
    bus.butc = 1'b1;
    expect_ev(c0 + 6, 5'h01, 5'h01, 1'b0, 16'h0000);
    expect_ev(c0 + 26, 5'h00, 5'h01, 1'b0, 16'h0000);
    expect_ev(c0 + 34, 5'h00, 5'h01, 1'b0, 16'h0000);
    expect_ev(c0 + 42, 5'h00, 5'h01, 1'b0, 16'h0000);
    go(c0 + 10);
    chk("butc_level_held", 32'(bus.btn_level), 32'h01);
    go(c0 + 43);
    bus.butc = 1'b0;
    go(c0 + 52);
    chk("butc_level_released", 32'(bus.btn_level), 32'h00);
    // butu bounces then holds
    c0 = cyc;
    bus.butu = 1'b1;
    go(c0 + 1);
    bus.butu = 1'b0;
    go(c0 + 2);
    bus.butu = 1'b1;
    go(c0 + 3);
    bus.butu = 1'b0;
    go(c0 + 4);
    bus.butu = 1'b1;
    expect_ev(c0 + 10, 5'h02, 5'h02, 1'b0, 16'h0000);
    go(c0 + 12);
    bus.butu = 1'b0;
    go(c0 + 20);
    // butd released before the repeat delay expires
    c0 = cyc;
    bus.butd = 1'b1;
    expect_ev(c0 + 6, 5'h04, 5'h04, 1'b0, 16'h0000);
    go(c0 + 15);
    bus.butd = 1'b0;
    go(c0 + 22);
    chk("butd_level_released", 32'(bus.btn_level), 32'h00);
    go(c0 + 40);
    // switches: clean change, then two toggles two cycles apart
    c0 = cyc;
    bus.sw = 16'h00A5;
    expect_ev(c0 + 6, 5'h00, 5'h00, 1'b1, 16'h00A5);
    go(c0 + 10);
    c0 = cyc;
    bus.sw = 16'h00A4;
    go(c0 + 2);
    bus.sw = 16'h00A6;
    expect_ev(c0 + 8, 5'h00, 5'h00, 1'b1, 16'h00A6);
    go(c0 + 7);
    chk("sw_not_yet_committed", 32'(bus.sw_stable), 32'h00A5);
    go(c0 + 12);
    // reset while butl is auto-repeating
    c0 = cyc;
    bus.butl = 1'b1;
    expect_ev(c0 + 6, 5'h08, 5'h08, 1'b0, 16'h00A6);
    expect_ev(c0 + 26, 5'h00, 5'h08, 1'b0, 16'h00A6);
    expect_ev(c0 + 34, 5'h00, 5'h08, 1'b0, 16'h00A6);
    go(c0 + 37);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrep_reset");
    go(c0 + 40);
    rstn = 1'b1;
    c0 = cyc;
    expect_ev(c0 + 6, 5'h08, 5'h08, 1'b1, 16'h00A6);
    go(c0 + 8);
    bus.butl = 1'b0;
    go(c0 + 15);
    chk("butl_level_released", 32'(bus.btn_level), 32'h00);
    go(c0 + 20);
    // reset with all switches on
    bus.sw = 16'hFFFF;
    rstn = 1'b0;
    go(cyc + 2);
    rstn = 1'b1;
    c0 = cyc;
    expect_ev(c0 + 6, 5'h00, 5'h00, 1'b1, 16'hFFFF);
    go(c0 + 5);
    chk("sw_before_commit", 32'(bus.sw_stable), 32'h0000);
    go(c0 + 20);
    chk("sw_after_commit", 32'(bus.sw_stable), 32'hFFFF);
    chk("events_pending", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
